// File: rtl/renode_axi_burst_sequencer_if.sv
// rtl/renode_axi_burst_sequencer_if.sv - command/beat handshake bundle for the burst sequencer
// master: the datapath offering commands and consuming beats; slave: the sequencer.
interface renode_axi_burst_sequencer_if #(
   parameter int AddressWidth = 32
) ();
   logic                    cmd_valid;
   logic                    cmd_ready;
   logic [AddressWidth-1:0] cmd_addr;
   logic [7:0]              cmd_len;
   logic [2:0]              cmd_size;
   logic [1:0]              cmd_burst;
   logic                    beat_valid;
   logic                    beat_ready;
   logic [AddressWidth-1:0] beat_addr;
   logic [7:0]              beat_index;
   logic                    beat_last;
   logic [1:0]              beat_resp;

   modport master (
      output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
      input  cmd_ready, beat_valid, beat_addr, beat_index, beat_last, beat_resp
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
      output cmd_ready, beat_valid, beat_addr, beat_index, beat_last, beat_resp
   );
endinterface

// File: rtl/renode_axi_burst_sequencer.sv
// rtl/renode_axi_burst_sequencer.sv - per-beat AXI burst address sequencer with legality check
// Accepts one AW/AR command in IDLE and emits len+1 registered beat descriptors in BURST.
module renode_axi_burst_sequencer #(
   parameter int AddressWidth = 32,
   parameter int DataWidth    = 32
) (
   input logic                         aclk,
   input logic                         areset_n,
   renode_axi_burst_sequencer_if.slave bus
);
   localparam logic [1:0] BurstFixed     = 2'd0;
   localparam logic [1:0] BurstIncr      = 2'd1;
   localparam logic [1:0] BurstWrap      = 2'd2;
   localparam logic [1:0] BurstReserved  = 2'd3;
   localparam logic [1:0] RespOkay       = 2'b00;
   localparam logic [1:0] RespSlaveError = 2'b10;
   localparam int         MaxSize        = $clog2(DataWidth / 8);

   typedef logic [AddressWidth-1:0] addr_t;
   typedef enum logic {IDLE, BURST} state_t;

   state_t     state_q, state_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic       beat_valid_q, beat_valid_d;
   addr_t      beat_addr_q, beat_addr_d;
   logic [7:0] beat_index_q, beat_index_d;
   logic       beat_last_q, beat_last_d;
   logic [1:0] beat_resp_q, beat_resp_d;
   logic [7:0] len_q, len_d;
   logic [1:0] burst_q, burst_d;
   logic       err_q, err_d;
   addr_t      step_q, step_d;
   addr_t      mask_q, mask_d;

   addr_t cmd_step;
   addr_t cmd_wrap_mask;
   logic  cmd_len_ok;
   logic  cmd_err;
   addr_t next_addr;

   // Wrap window W = (len+1) << size; only meaningful when len+1 is a power of two.
   assign cmd_step      = addr_t'(1) << bus.cmd_size;
   assign cmd_wrap_mask = ((addr_t'(bus.cmd_len) + addr_t'(1)) << bus.cmd_size) - addr_t'(1);
   assign cmd_len_ok    = (bus.cmd_len == 8'd1) || (bus.cmd_len == 8'd3) ||
                          (bus.cmd_len == 8'd7) || (bus.cmd_len == 8'd15);
   assign cmd_err       = (bus.cmd_burst == BurstReserved) ||
                          (int'(bus.cmd_size) > MaxSize) ||
                          ((bus.cmd_burst == BurstWrap) && !cmd_len_ok) ||
                          ((bus.cmd_burst == BurstWrap) &&
                           ((bus.cmd_addr & (cmd_step - addr_t'(1))) != '0));

   // Error bursts and fixed bursts keep the start address on every beat.
   always_comb begin
      next_addr = beat_addr_q;
      if (!err_q) begin
         case (burst_q)
            BurstIncr: next_addr = (beat_addr_q & ~(step_q - addr_t'(1))) + step_q;
            BurstWrap: next_addr = (beat_addr_q & ~mask_q) | ((beat_addr_q + step_q) & mask_q);
            default:   next_addr = beat_addr_q;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = cmd_ready_q;
      beat_valid_d = beat_valid_q;
      beat_addr_d  = beat_addr_q;
      beat_index_d = beat_index_q;
      beat_last_d  = beat_last_q;
      beat_resp_d  = beat_resp_q;
      len_d        = len_q;
      burst_d      = burst_q;
      err_d        = err_q;
      step_d       = step_q;
      mask_d       = mask_q;
      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (bus.cmd_valid && cmd_ready_q) begin
               state_d      = BURST;
               cmd_ready_d  = 1'b0;
               beat_valid_d = 1'b1;
               beat_addr_d  = bus.cmd_addr;
               beat_index_d = 8'd0;
               beat_last_d  = (bus.cmd_len == 8'd0);
               beat_resp_d  = cmd_err ? RespSlaveError : RespOkay;
               len_d        = bus.cmd_len;
               burst_d      = bus.cmd_burst;
               err_d        = cmd_err;
               step_d       = cmd_step;
               mask_d       = cmd_wrap_mask;
            end
         end
         BURST: begin
            if (beat_valid_q && bus.beat_ready) begin
               if (beat_last_q) begin
                  state_d      = IDLE;
                  beat_valid_d = 1'b0;
                  beat_last_d  = 1'b0;
                  cmd_ready_d  = 1'b1;
               end else begin
                  beat_index_d = beat_index_q + 8'd1;
                  beat_addr_d  = next_addr;
                  beat_last_d  = ((beat_index_q + 8'd1) == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q      <= IDLE;
         cmd_ready_q  <= 1'b0;
         beat_valid_q <= 1'b0;
         beat_addr_q  <= '0;
         beat_index_q <= 8'd0;
         beat_last_q  <= 1'b0;
         beat_resp_q  <= RespOkay;
         len_q        <= 8'd0;
         burst_q      <= BurstFixed;
         err_q        <= 1'b0;
         step_q       <= '0;
         mask_q       <= '0;
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         beat_valid_q <= beat_valid_d;
         beat_addr_q  <= beat_addr_d;
         beat_index_q <= beat_index_d;
         beat_last_q  <= beat_last_d;
         beat_resp_q  <= beat_resp_d;
         len_q        <= len_d;
         burst_q      <= burst_d;
         err_q        <= err_d;
         step_q       <= step_d;
         mask_q       <= mask_d;
      end
   end

   assign bus.cmd_ready  = cmd_ready_q;
   assign bus.beat_valid = beat_valid_q;
   assign bus.beat_addr  = beat_addr_q;
   assign bus.beat_index = beat_index_q;
   assign bus.beat_last  = beat_last_q;
   assign bus.beat_resp  = beat_resp_q;
endmodule

// File: tb/tb_renode_axi_burst_sequencer.sv
// tb/tb_renode_axi_burst_sequencer.sv - directed scoreboard bench for the burst sequencer
module tb_renode_axi_burst_sequencer;
   logic aclk = 1'b0;
   logic areset_n = 1'b0;
   always #5 aclk = ~aclk;

   renode_axi_burst_sequencer_if #(.AddressWidth(32)) bus ();

   renode_axi_burst_sequencer #(.AddressWidth(32), .DataWidth(32)) dut (
      .aclk     (aclk),
      .areset_n (areset_n),
      .bus      (bus)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  idx;
      logic        last;
      logic [1:0]  resp;
   } beat_t;

   beat_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference beats straight from the address and legality rules (bus is 4 bytes wide).
   function automatic void push_expected(input logic [31:0] a, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] s, w, lower, cur, nxt;
      logic        err;
      beat_t       b;
      s     = 32'd1 << size;
      w     = (32'(len) + 32'd1) * s;
      lower = a & ~(w - 32'd1);
      err   = (burst == 2'd3) || (size > 3'd2) ||
              ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) ||
              ((burst == 2'd2) && ((a % s) != 32'd0));
      cur   = a;
      for (int i = 0; i <= int'(len); i++) begin
         b.idx  = 8'(i);
         b.last = (i == int'(len));
         b.resp = err ? 2'b10 : 2'b00;
         if (err || burst == 2'd0) b.addr = a;
         else if (burst == 2'd1)   b.addr = (i == 0) ? a : (a & ~(s - 32'd1)) + 32'(i) * s;
         else                      b.addr = cur;
         nxt = cur + s;
         if (nxt == lower + w) nxt = lower;
         cur = nxt;
         exp_q.push_back(b);
      end
   endfunction

   task automatic do_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit stall, input int max_beats,
                           input string tag);
      int          n, k;
      bit          held;
      beat_t       e;
      logic [31:0] h_addr;
      logic [7:0]  h_idx;
      logic        h_last;
      logic [1:0]  h_resp;
      push_expected(a, len, size, burst);
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge aclk);
         n++;
      end
      check({tag, " cmd_ready idle"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_addr   = a;
      bus.cmd_len    = len;
      bus.cmd_size   = size;
      bus.cmd_burst  = burst;
      bus.cmd_valid  = 1'b1;
      bus.beat_ready = 1'b0;
      @(negedge aclk);
      bus.cmd_valid = 1'b0;
      check({tag, " first beat_valid"}, 32'(bus.beat_valid), 32'd1);
      n = 0;
      k = 0;
      held = 1'b0;
      while (n < max_beats && k < 200) begin
         if (held) begin
            check({tag, " stall addr"}, bus.beat_addr, h_addr);
            check({tag, " stall index"}, 32'(bus.beat_index), 32'(h_idx));
            check({tag, " stall last"}, 32'(bus.beat_last), 32'(h_last));
            check({tag, " stall resp"}, 32'(bus.beat_resp), 32'(h_resp));
         end
         check({tag, " cmd_ready busy"}, 32'(bus.cmd_ready), 32'd0);
         bus.beat_ready = stall ? (k % 3 == 0) : 1'b1;
         if (stall) begin
            bus.cmd_valid = (k % 2 == 1);
            bus.cmd_addr  = 32'hDEAD0000;
            bus.cmd_len   = 8'd0;
         end
         if (bus.beat_valid && bus.beat_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, " unexpected beat"}, 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check({tag, " addr"}, bus.beat_addr, e.addr);
               check({tag, " index"}, 32'(bus.beat_index), 32'(e.idx));
               check({tag, " last"}, 32'(bus.beat_last), 32'(e.last));
               check({tag, " resp"}, 32'(bus.beat_resp), 32'(e.resp));
            end
            n++;
            held = 1'b0;
         end else begin
            held   = 1'b1;
            h_addr = bus.beat_addr;
            h_idx  = bus.beat_index;
            h_last = bus.beat_last;
            h_resp = bus.beat_resp;
         end
         k++;
         @(negedge aclk);
      end
      bus.beat_ready = 1'b0;
      bus.cmd_valid  = 1'b0;
      check({tag, " beat count"}, 32'(n), 32'(max_beats));
      if (n == int'(len) + 1) begin
         check({tag, " beat_valid after last"}, 32'(bus.beat_valid), 32'd0);
         check({tag, " cmd_ready after last"}, 32'(bus.cmd_ready), 32'd1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_addr   = 32'd0;
      bus.cmd_len    = 8'd0;
      bus.cmd_size   = 3'd0;
      bus.cmd_burst  = 2'd0;
      bus.beat_ready = 1'b0;
      areset_n       = 1'b0;
      repeat (2) @(negedge aclk);
      check("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("reset beat_valid", 32'(bus.beat_valid), 32'd0);
      check("reset beat_addr", bus.beat_addr, 32'd0);
      check("reset beat_index", 32'(bus.beat_index), 32'd0);
      check("reset beat_last", 32'(bus.beat_last), 32'd0);
      check("reset beat_resp", 32'(bus.beat_resp), 32'd0);
      areset_n = 1'b1;
      #1 check("release cmd_ready low", 32'(bus.cmd_ready), 32'd0);
      @(negedge aclk);
      check("release cmd_ready high", 32'(bus.cmd_ready), 32'd1);

      do_burst(32'h0000_1004, 8'd3, 3'd2, 2'd0, 1'b0, 4, "fixed");
      do_burst(32'h0000_1002, 8'd2, 3'd2, 2'd1, 1'b0, 3, "incr_unaligned");
      do_burst(32'h0000_1038, 8'd3, 3'd2, 2'd2, 1'b0, 4, "wrap");
      do_burst(32'h0000_2000, 8'd1, 3'd2, 2'd3, 1'b0, 2, "err_reserved");
      do_burst(32'h0000_1000, 8'd2, 3'd2, 2'd2, 1'b0, 3, "err_wrap_len");
      do_burst(32'h0000_1039, 8'd3, 3'd2, 2'd2, 1'b0, 4, "err_wrap_align");
      do_burst(32'h0000_3000, 8'd3, 3'd3, 2'd1, 1'b0, 4, "err_size");
      do_burst(32'hFFFF_FFF8, 8'd3, 3'd2, 2'd1, 1'b0, 4, "incr_addr_wrap");
      do_burst(32'h0000_0000, 8'd7, 3'd2, 2'd1, 1'b1, 8, "backpressure");

      do_burst(32'h0000_0100, 8'd7, 3'd2, 2'd1, 1'b0, 2, "rst_mid");
      areset_n = 1'b0;
      #1;
      check("rst_mid beat_valid drop", 32'(bus.beat_valid), 32'd0);
      check("rst_mid beat_index clear", 32'(bus.beat_index), 32'd0);
      check("rst_mid beat_addr clear", bus.beat_addr, 32'd0);
      exp_q.delete();
      @(negedge aclk);
      @(negedge aclk);
      areset_n = 1'b1;
      #1 check("rst_mid cmd_ready low", 32'(bus.cmd_ready), 32'd0);
      @(negedge aclk);
      check("rst_mid cmd_ready high", 32'(bus.cmd_ready), 32'd1);
      do_burst(32'h0000_0040, 8'd0, 3'd2, 2'd1, 1'b0, 1, "len0");

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
